// File: rtl/key_step_conditioner.sv
// key_step_conditioner
//   Turns a raw, bouncing, active-low push button into clean single-cycle step
//   pulses on the system clock. The button passes through a 2-flop
//   synchroniser and a debounce FSM. Optional auto-repeat issues further steps
//   while the key is held. Steps are counted modulo 256 for a display.
//
// Ports
//   clock       in   system clock; all state changes on the rising edge
//   reset_n     in   synchronous, active-low reset
//   key_n       in   raw button, asynchronous, 0 = pressed
//   repeat_en   in   1 = auto-repeat while the key is held
//   step        out  one-cycle step pulse (registered)
//   pressed     out  debounced button level (registered)
//   step_count  out  number of steps issued, modulo 256
//   state       out  FSM state, for a debug display
module key_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_n,
  input  logic       repeat_en,
  output logic       step,
  output logic       pressed,
  output logic [7:0] step_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD_DLY = 3'd2,
    HELD_RPT = 3'd3,
    REL_DB   = 3'd4
  } state_t;

  // Terminal values of the shared counter: a count of N runs 0 .. N-1.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             key_sync_p0;
  logic             key_s_p1;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Stage p0/p1: two-flop synchroniser, inverted so key_s_p1 = 1 means pressed.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      key_sync_p0 <= 1'b0;
      key_s_p1    <= 1'b0;
    end else begin
      key_sync_p0 <= ~key_n;
      key_s_p1    <= key_sync_p0;
    end
  end

  // Debounce / auto-repeat FSM. A release is always tested before any
  // terminal count, so a release on the terminal cycle issues no step.
  // pressed is written in every branch so it reflects the next state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      step       <= 1'b0;
      pressed    <= 1'b0;
      step_count <= 8'd0;
    end else begin
      step <= 1'b0;
      case (state_q)
        IDLE: begin
          pressed <= 1'b0;
          if (key_s_p1) begin
            cnt_q   <= '0;
            state_q <= PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (!key_s_p1) begin
            pressed <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == DB_LAST) begin
            cnt_q      <= '0;
            step       <= 1'b1;
            step_count <= step_count + 8'd1;
            pressed    <= 1'b1;
            state_q    <= HELD_DLY;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            pressed <= 1'b0;
          end
        end
        HELD_DLY: begin
          pressed <= 1'b1;
          if (!key_s_p1) begin
            cnt_q   <= '0;
            state_q <= REL_DB;
          end else if (!repeat_en) begin
            cnt_q <= '0;
          end else if (cnt_q == DLY_LAST) begin
            cnt_q      <= '0;
            step       <= 1'b1;
            step_count <= step_count + 8'd1;
            state_q    <= HELD_RPT;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HELD_RPT: begin
          pressed <= 1'b1;
          if (!key_s_p1) begin
            cnt_q   <= '0;
            state_q <= REL_DB;
          end else if (!repeat_en) begin
            cnt_q   <= '0;
            state_q <= HELD_DLY;
          end else if (cnt_q == RPT_LAST) begin
            cnt_q      <= '0;
            step       <= 1'b1;
            step_count <= step_count + 8'd1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        REL_DB: begin
          if (key_s_p1) begin
            // Re-press bounce during release: back to held, no new step.
            cnt_q   <= '0;
            pressed <= 1'b1;
            state_q <= HELD_DLY;
          end else if (cnt_q == DB_LAST) begin
            pressed <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            pressed <= 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          pressed <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Bench for key_step_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=3. A deadline-based model (each timed state records the edge
// number at which it expires) predicts step/pressed/step_count/state for every
// edge; directed scenarios add hand-computed literal expectations.
module tb_key_step_conditioner;
  localparam int D = 4;
  localparam int R = 8;
  localparam int P = 3;

  logic       clock     = 1'b0;
  logic       reset_n   = 1'b0;
  logic       key_n     = 1'b1;
  logic       repeat_en = 1'b0;
  logic       step;
  logic       pressed;
  logic [7:0] step_count;
  logic [2:0] state;

  key_step_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (R),
    .REPEAT_PERIOD  (P),
    .CNT_W          (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key_n     (key_n),
    .repeat_en (repeat_en),
    .step      (step),
    .pressed   (pressed),
    .step_count(step_count),
    .state     (state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = -1;

  // Model state: sync pipeline, mode (0..4), expiry edge, outputs.
  int m_k1 = 0, m_ks = 0, m_mode = 0, m_dl = 0;
  int m_step = 0, m_pressed = 0, m_count = 0;
  int step_edges[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic enter(input int mode, input int n);
    m_mode = mode;
    m_dl   = cyc + n;
  endtask

  task automatic model_edge();
    int ks;
    if (!reset_n) begin
      m_k1 = 0; m_ks = 0; m_mode = 0; m_dl = 0;
      m_step = 0; m_pressed = 0; m_count = 0;
    end else begin
      ks     = m_ks;
      m_ks   = m_k1;
      m_k1   = key_n ? 0 : 1;
      m_step = 0;
      case (m_mode)
        0: if (ks != 0) enter(1, D);
        1: begin
          if (ks == 0) m_mode = 0;
          else if (cyc == m_dl) begin m_step = 1; enter(2, R); end
        end
        2, 3: begin
          if (ks == 0) enter(4, D);
          else if (!repeat_en) enter(2, R);
          else if (cyc == m_dl) begin m_step = 1; enter(3, P); end
        end
        4: begin
          if (ks != 0) enter(2, R);
          else if (cyc == m_dl) m_mode = 0;
        end
        default: m_mode = 0;
      endcase
      m_pressed = (m_mode >= 2) ? 1 : 0;
      if (m_step != 0) m_count = (m_count + 1) % 256;
    end
  endtask

  // One active edge: advance the model, then compare on the falling edge.
  task automatic tick();
    @(posedge clock);
    cyc++;
    model_edge();
    if (m_step != 0) step_edges.push_back(cyc);
    @(negedge clock);
    check("step", step, m_step);
    check("pressed", pressed, m_pressed);
    check("step_count", step_count, m_count);
    check("state", state, m_mode);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    key_n   = 1'b1;
    reset_n = 1'b0;
    ticks(2);
    check("reset_state", state, 0);
    check("reset_step_count", step_count, 0);
    check("reset_pressed", pressed, 0);
    reset_n = 1'b1;
    ticks(1);
  endtask

  int e0;
  int r0;
  int x;

  initial begin
    // 1: single debounced press, no repeat
    do_reset();
    repeat_en = 1'b0;
    step_edges.delete();
    key_n = 1'b0;
    e0 = cyc + 1;
    ticks(20);
    check("t1_num_steps", step_edges.size(), 1);
    if (step_edges.size() > 0) check("t1_step_edge", step_edges[0] - e0, 6);
    check("t1_step_count", step_count, 1);
    check("t1_pressed", pressed, 1);
    key_n = 1'b1;
    e0 = cyc + 1;
    ticks(6);
    check("t1_rel_pressed_hold", pressed, 1);
    ticks(1);
    check("t1_rel_pressed", pressed, 0);
    check("t1_rel_state", state, 0);

    // 2: short bounce rejected
    do_reset();
    step_edges.delete();
    key_n = 1'b0;
    ticks(3);
    key_n = 1'b1;
    ticks(1);
    check("t2_state_press_db", state, 1);
    ticks(8);
    check("t2_num_steps", step_edges.size(), 0);
    check("t2_step_count", step_count, 0);
    check("t2_state_idle", state, 0);

    // 3: auto-repeat while held for 40 edges
    do_reset();
    step_edges.delete();
    repeat_en = 1'b1;
    key_n = 1'b0;
    e0 = cyc + 1;
    ticks(40);
    check("t3_num_steps", step_edges.size(), 10);
    if (step_edges.size() >= 10) begin
      check("t3_first_step", step_edges[0] - e0, 6);
      check("t3_first_repeat", step_edges[1] - e0, 14);
      check("t3_second_repeat", step_edges[2] - e0, 17);
      check("t3_last_repeat", step_edges[9] - e0, 38);
    end
    check("t3_step_count", step_count, 10);

    // 4: release from HELD_RPT with a 2-edge re-press bounce
    r0 = cyc + 1;
    key_n = 1'b1;
    ticks(2);
    step_edges.delete();
    key_n = 1'b0;
    ticks(2);
    key_n = 1'b1;
    ticks(1);
    check("t4_bounce_state", state, 2);
    check("t4_bounce_pressed", pressed, 1);
    ticks(5);
    check("t4_rel_db_state", state, 4);
    check("t4_rel_db_pressed", pressed, 1);
    ticks(1);
    check("t4_idle_state", state, 0);
    check("t4_idle_pressed", pressed, 0);
    check("t4_no_extra_step", step_edges.size(), 0);

    // 5: 260 auto-repeat steps, count wraps
    do_reset();
    step_edges.delete();
    repeat_en = 1'b1;
    key_n = 1'b0;
    e0 = cyc + 1;
    for (int i = 0; i < 1000 && step_edges.size() < 260; i++) tick();
    check("t5_num_steps", step_edges.size(), 260);
    if (step_edges.size() == 260) check("t5_last_step_edge", step_edges[259] - e0, 788);
    check("t5_step_count", step_count, 4);

    // 6: one-edge reset while held in HELD_RPT
    check("t6_pre_state", state, 3);
    reset_n = 1'b0;
    x = cyc + 1;
    ticks(1);
    check("t6_rst_state", state, 0);
    check("t6_rst_step", step, 0);
    check("t6_rst_pressed", pressed, 0);
    check("t6_rst_count", step_count, 0);
    reset_n = 1'b1;
    step_edges.delete();
    ticks(10);
    check("t6_num_steps", step_edges.size(), 1);
    if (step_edges.size() > 0) check("t6_step_edge", step_edges[0] - x, 7);
    check("t6_step_count", step_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
